avalon_fft_loader: RTL and testbench

Parametrised Avalon-MM slave that sits between the host interconnect and the FFT core. It replaces the fixed 32-bit/512-point slave with a register-mapped front end. It loads a programmable number of samples into the FFT input buffer, starts the FFT manually or automatically, and tracks completion with sticky status and an interrupt. It also exposes the FFT result memory through a pipelined read window.

---
 rtl/avalon_fft_loader.sv | 193 +++++++++++++++++++
 tb/tb_avalon_fft_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_fft_loader.sv
// Avalon-MM register front end for the FFT core: loads a programmable number of
// samples, starts the transform, tracks completion and exposes the result memory.
module avalon_fft_loader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LOG2N  = 9,
  parameter int unsigned ADDR_W = LOG2N + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] fft_init_data,
  output logic [LOG2N-1:0]  fft_wAddress,
  output logic              fft_wEn,
  output logic              fft_start,
  input  logic              fft_done,
  output logic [LOG2N-1:0]  res_addr,
  output logic              res_rd,
  input  logic [DATA_W-1:0] res_data,
  output logic              irq
);

  typedef enum logic [2:0] {IDLE, LOAD, FULL, START, RUN} state_t;

  localparam logic [LOG2N:0]    N_LEN   = {1'b1, {LOG2N{1'b0}}};
  localparam logic [LOG2N:0]    ONE_LEN = {{LOG2N{1'b0}}, 1'b1};
  localparam logic [ADDR_W-2:0] A_CTRL  = (ADDR_W-1)'(0);
  localparam logic [ADDR_W-2:0] A_STAT  = (ADDR_W-1)'(1);
  localparam logic [ADDR_W-2:0] A_LEN   = (ADDR_W-1)'(2);
  localparam logic [ADDR_W-2:0] A_SMPL  = (ADDR_W-1)'(3);

  state_t            state, state_nx;
  logic [LOG2N:0]    ptr, len;
  logic              irq_en, auto_start, done, overflow, start_err;

  logic              csr_sel;
  logic [ADDR_W-2:0] reg_idx;
  logic              wr_ctrl, wr_stat, wr_len, wr_smpl;
  logic              start_req, soft_clr, len_ok;
  logic              sample_acc, ovf_set, serr_set, done_set;

  logic [DATA_W-1:0] csr_rdata, csr_q;
  logic              rd_v1, rd_res1;

  assign csr_sel   = ~avs_address[ADDR_W-1];
  assign reg_idx   = avs_address[ADDR_W-2:0];
  assign wr_ctrl   = avs_write & csr_sel & (reg_idx == A_CTRL);
  assign wr_stat   = avs_write & csr_sel & (reg_idx == A_STAT);
  assign wr_len    = avs_write & csr_sel & (reg_idx == A_LEN);
  assign wr_smpl   = avs_write & csr_sel & (reg_idx == A_SMPL);
  assign start_req = wr_ctrl & avs_writedata[0];
  assign soft_clr  = wr_ctrl & avs_writedata[1];
  assign len_ok    = (avs_writedata != '0) && (avs_writedata <= DATA_W'(N_LEN));

  assign avs_waitrequest = 1'b0;
  assign irq             = done & irq_en;
  assign res_rd          = avs_read & avs_address[ADDR_W-1];
  assign res_addr        = res_rd ? avs_address[LOG2N-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // LOAD checks the registered ptr, so the last accepted sample is followed by one
  // LOAD cycle before START; that extra cycle sets the auto-start latency.
  always_comb begin
    state_nx   = state;
    sample_acc = 1'b0;
    ovf_set    = 1'b0;
    serr_set   = 1'b0;
    done_set   = 1'b0;
    fft_start  = (state == START);
    if (soft_clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          serr_set = start_req;
          if (wr_smpl) begin
            sample_acc = 1'b1;
            state_nx   = (len == ONE_LEN && !auto_start) ? FULL : LOAD;
          end
        end
        LOAD: begin
          serr_set = start_req;
          if (ptr == len) begin
            state_nx = auto_start ? START : FULL;
            ovf_set  = wr_smpl;
          end else begin
            sample_acc = wr_smpl;
          end
        end
        FULL: begin
          ovf_set = wr_smpl;
          if (start_req) state_nx = START;
        end
        START: begin
          ovf_set  = wr_smpl;
          state_nx = RUN;
        end
        RUN: begin
          ovf_set  = wr_smpl;
          serr_set = start_req;
          if (fft_done) begin
            done_set = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len           <= N_LEN;
      ptr           <= '0;
      irq_en        <= 1'b0;
      auto_start    <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      start_err     <= 1'b0;
      fft_wEn       <= 1'b0;
      fft_wAddress  <= '0;
      fft_init_data <= '0;
    end else begin
      fft_wEn <= sample_acc;
      if (sample_acc) begin
        fft_wAddress  <= ptr[LOG2N-1:0];
        fft_init_data <= avs_writedata;
      end
      if (wr_ctrl) begin
        irq_en     <= avs_writedata[2];
        auto_start <= avs_writedata[3];
      end
      if (wr_len && state == IDLE)
        len <= len_ok ? avs_writedata[LOG2N:0] : N_LEN;
      if (soft_clr || done_set) ptr <= '0;
      else if (sample_acc)      ptr <= ptr + 1'b1;
      // Set has priority over write-one-to-clear; soft_clear beats both.
      if (soft_clr)                           done <= 1'b0;
      else if (done_set)                      done <= 1'b1;
      else if (wr_stat && avs_writedata[1])   done <= 1'b0;
      if (soft_clr)                           overflow <= 1'b0;
      else if (ovf_set)                       overflow <= 1'b1;
      else if (wr_stat && avs_writedata[2])   overflow <= 1'b0;
      if (soft_clr)                           start_err <= 1'b0;
      else if (serr_set)                      start_err <= 1'b1;
      else if (wr_stat && avs_writedata[3])   start_err <= 1'b0;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (reg_idx)
      A_CTRL: csr_rdata[3:2] = {auto_start, irq_en};
      A_STAT: begin
        csr_rdata[0]            = (state == RUN);
        csr_rdata[1]            = done;
        csr_rdata[2]            = overflow;
        csr_rdata[3]            = start_err;
        csr_rdata[LOG2N+16:16]  = ptr;
      end
      A_LEN:  csr_rdata[LOG2N:0] = len;
      default: csr_rdata = '0;
    endcase
  end

  // Two-stage read pipeline: CSR data is captured at request, result data one
  // cycle later when the result memory presents it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1             <= 1'b0;
      rd_res1           <= 1'b0;
      csr_q             <= '0;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
    end else begin
      rd_v1             <= avs_read;
      rd_res1           <= res_rd;
      if (avs_read) csr_q <= csr_rdata;
      avs_readdatavalid <= rd_v1;
      if (rd_v1) avs_readdata <= rd_res1 ? res_data : csr_q;
    end
  end

endmodule

// File: tb/tb_avalon_fft_loader.sv
// Directed bench for avalon_fft_loader: CSR access, load/start/complete flows,
// overflow and start errors, pipelined result reads, soft clear and reset.
module tb_avalon_fft_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_readdatavalid, avs_waitrequest;
  logic [31:0] fft_init_data;
  logic [8:0]  fft_wAddress;
  logic        fft_wEn, fft_start, fft_done;
  logic [8:0]  res_addr;
  logic        res_rd;
  logic [31:0] res_data;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  avalon_fft_loader #(.DATA_W(32), .LOG2N(9), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
    .fft_init_data(fft_init_data), .fft_wAddress(fft_wAddress), .fft_wEn(fft_wEn),
    .fft_start(fft_start), .fft_done(fft_done),
    .res_addr(res_addr), .res_rd(res_rd), .res_data(res_data), .irq(irq)
  );

  always #5 clk = ~clk;

  // Result memory: one-cycle read latency, contents = address * 3.
  always @(posedge clk) begin
    if (rst)         res_data <= 32'd0;
    else if (res_rd) res_data <= {23'd0, res_addr} * 32'd3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
    avs_address = a;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    chk({tag, "_early"}, {31'd0, avs_readdatavalid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, avs_readdatavalid}, 32'd1);
    chk(tag, avs_readdata, exp);
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; fft_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_wen",   {31'd0, fft_wEn}, 32'd0);
    chk("rst_start", {31'd0, fft_start}, 32'd0);
    chk("rst_irq",   {31'd0, irq}, 32'd0);
    chk("rst_rdv",   {31'd0, avs_readdatavalid}, 32'd0);
    chk("rst_wait",  {31'd0, avs_waitrequest}, 32'd0);
    rd("rst_status", 10'd1, 32'h0);
    rd("rst_len",    10'd2, 32'd512);
    rd("rst_ctrl",   10'd0, 32'h0);
    rd("unmapped",   10'd5, 32'h0);

    // Auto-start load of four samples
    wr(10'd2, 32'd4);
    wr(10'd0, 32'h8);
    for (int i = 0; i < 4; i++) begin
      wr(10'd3, 32'hA0 + 32'(i));
      chk("auto_wen",  {31'd0, fft_wEn}, 32'd1);
      chk("auto_addr", {23'd0, fft_wAddress}, 32'(i));
      chk("auto_data", fft_init_data, 32'hA0 + 32'(i));
    end
    chk("auto_start_t1", {31'd0, fft_start}, 32'd0);
    tick();
    chk("auto_start_t2", {31'd0, fft_start}, 32'd1);
    chk("auto_wen_off",  {31'd0, fft_wEn}, 32'd0);
    tick();
    chk("auto_start_t3", {31'd0, fft_start}, 32'd0);
    rd("run_status", 10'd1, 32'h0004_0001);
    pulse_done();
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    rd("done_status", 10'd1, 32'h2);
    wr(10'd0, 32'hC);
    chk("irq_enabled", {31'd0, irq}, 32'd1);
    wr(10'd1, 32'h2);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd("ctrl_rb", 10'd0, 32'hC);

    // Manual start with overflow
    wr(10'd2, 32'd2);
    wr(10'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      wr(10'd3, 32'hB0 + 32'(i));
      chk("ovf_wen", {31'd0, fft_wEn}, (i < 2) ? 32'd1 : 32'd0);
      if (i < 2) chk("ovf_addr", {23'd0, fft_wAddress}, 32'(i));
    end
    chk("full_nostart", {31'd0, fft_start}, 32'd0);
    rd("full_status", 10'd1, 32'h0002_0004);
    wr(10'd0, 32'h1);
    chk("man_start", {31'd0, fft_start}, 32'd1);
    tick();
    chk("man_start_off", {31'd0, fft_start}, 32'd0);
    rd("run_ovf_status", 10'd1, 32'h0002_0005);
    wr(10'd1, 32'hE);
    rd("w1c_status", 10'd1, 32'h0002_0001);
    avs_address = 10'd1; avs_writedata = 32'h2; avs_write = 1'b1; fft_done = 1'b1;
    tick();
    avs_write = 1'b0; fft_done = 1'b0;
    rd("done_wins", 10'd1, 32'h2);

    // Start error, LEN boundaries, LEN frozen during RUN
    wr(10'd0, 32'h1);
    chk("idle_start0", {31'd0, fft_start}, 32'd0);
    tick();
    chk("idle_start1", {31'd0, fft_start}, 32'd0);
    rd("serr_status", 10'd1, 32'hA);
    wr(10'd1, 32'hE);
    rd("clr_status", 10'd1, 32'h0);
    wr(10'd2, 32'd1);
    wr(10'd3, 32'hC0);
    chk("len1_wen",  {31'd0, fft_wEn}, 32'd1);
    chk("len1_addr", {23'd0, fft_wAddress}, 32'd0);
    chk("len1_data", fft_init_data, 32'hC0);
    rd("len1_status", 10'd1, 32'h0001_0000);
    wr(10'd0, 32'h1);
    chk("len1_start", {31'd0, fft_start}, 32'd1);
    tick();
    wr(10'd2, 32'd3);
    rd("len_frozen", 10'd2, 32'd1);
    pulse_done();
    rd("len1_done", 10'd1, 32'h2);
    wr(10'd2, 32'd0);
    rd("len_zero", 10'd2, 32'd512);
    wr(10'd2, 32'd600);
    rd("len_big", 10'd2, 32'd512);
    wr(10'd2, 32'd511);
    rd("len_511", 10'd2, 32'd511);
    wr(10'd1, 32'h2);

    // Back-to-back result window reads
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        avs_address = 10'h200 + 10'(k);
        avs_read    = 1'b1;
        #1;
        chk("res_rd",   {31'd0, res_rd}, 32'd1);
        chk("res_addr", {23'd0, res_addr}, 32'(k));
      end else begin
        avs_read = 1'b0;
      end
      tick();
      chk("res_valid", {31'd0, avs_readdatavalid}, (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
      if (k >= 1 && k <= 4) chk("res_data", avs_readdata, 32'(3 * (k - 1)));
    end

    // Soft clear in RUN, then a stale completion
    wr(10'd2, 32'd1);
    wr(10'd0, 32'h4);
    wr(10'd3, 32'hC1);
    wr(10'd0, 32'h5);
    chk("sc_start", {31'd0, fft_start}, 32'd1);
    tick();
    wr(10'd0, 32'h6);
    chk("sc_start_off", {31'd0, fft_start}, 32'd0);
    pulse_done();
    chk("sc_irq", {31'd0, irq}, 32'd0);
    rd("sc_status", 10'd1, 32'h0);

    // Reset mid-load with a read in flight
    wr(10'd2, 32'd4);
    wr(10'd0, 32'h0);
    wr(10'd3, 32'hD8);
    wr(10'd3, 32'hD9);
    avs_address = 10'd1; avs_read = 1'b1;
    tick();
    avs_read = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_rdv0", {31'd0, avs_readdatavalid}, 32'd0);
    chk("rst_wen0", {31'd0, fft_wEn}, 32'd0);
    tick();
    chk("rst_rdv1", {31'd0, avs_readdatavalid}, 32'd0);
    rd("rst_mid_status", 10'd1, 32'h0);
    rd("rst_mid_len", 10'd2, 32'd512);
    wr(10'd3, 32'hD0);
    chk("rst_mid_wen",  {31'd0, fft_wEn}, 32'd1);
    chk("rst_mid_addr", {23'd0, fft_wAddress}, 32'd0);
    chk("rst_mid_data", fft_init_data, 32'hD0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
